des_sbox_stage: RTL and testbench

DES_SBOX_STAGE -- requirements
Module: des_sbox_stage

---
 rtl/des_pkg.sv | 47 ++++
 rtl/des_sbox.sv | 18 +
 rtl/des_sbox_stage.sv | 101 ++++++++++
 tb/tb_des_sbox_stage.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// Shared definitions for the DES S-box stage: widths, FSM states, S-box and P tables.
// The P table is only consumed when des_sbox_stage is built with DES_SBOX_PPERM_EN.
package des_pkg;

  localparam int EXP_W      = 48;
  localparam int OUT_W      = 32;
  localparam int SBOX_IN_W  = 6;
  localparam int SBOX_OUT_W = 4;
  localparam int NUM_SBOX   = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // One 256-bit word per box (index 0 = S1); entry {row,col} sits at nibble row*16+col from the MSB.
  localparam logic [255:0] SBOX_TBL [NUM_SBOX] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D70934A6285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };

  // Entry i is the DES source bit (1-based) that lands on DES output bit i+1.
  localparam int P_TBL [OUT_W] = '{
    16,  7, 20, 21, 29, 12, 28, 17,
     1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,
    19, 13, 30,  6, 22, 11,  4, 25
  };

  // Vectors are [OUT_W:1] with DES bit k at index OUT_W+1-k.
  function automatic logic [OUT_W:1] p_perm(input logic [OUT_W:1] s);
    logic [OUT_W:1] r;
    r = '0;
    for (int i = 1; i <= OUT_W; i++) begin
      r[OUT_W + 1 - i] = s[OUT_W + 1 - P_TBL[i-1]];
    end
    return r;
  endfunction

endpackage

// File: rtl/des_sbox.sv
// Single combinational DES S-box: 6-bit input, 3-bit box select (0 = S1), 4-bit output.
module des_sbox
  import des_pkg::*;
(
  input  logic [SBOX_IN_W-1:0]  din,
  input  logic [2:0]            sel,
  output logic [SBOX_OUT_W-1:0] dout
);

  logic [5:0]   entry;
  logic [255:0] table_word;

  // Outer bits pick the row, middle four the column.
  assign entry      = {din[5], din[0], din[4:1]};
  assign table_word = SBOX_TBL[sel];
  assign dout       = table_word[255 - 4*int'(entry) -: SBOX_OUT_W];

endmodule

// File: rtl/des_sbox_stage.sv
// Multi-cycle DES S-box substitution stage, SBOX_PER_CYCLE boxes per RUN cycle.
// Define DES_SBOX_PPERM_EN to present the P-permuted result on sbox_out.
module des_sbox_stage
  import des_pkg::*;
#(
  parameter int SBOX_PER_CYCLE = 1
) (
  input  logic           clk,
  input  logic           n_rst,
  input  logic           in_valid,
  input  logic [EXP_W:1] expanded,
  input  logic [EXP_W:1] subkey,
  output logic           in_ready,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [OUT_W:1] sbox_out
);

  state_t         state_reg, state_next;
  logic [EXP_W:1] x_reg, x_next;
  logic [OUT_W:1] result_reg, result_next;
  logic [2:0]     idx_reg, idx_next;
  logic           last_step;

  logic [2:0]            box_sel  [SBOX_PER_CYCLE];
  logic [SBOX_IN_W-1:0]  box_din  [SBOX_PER_CYCLE];
  logic [SBOX_OUT_W-1:0] box_dout [SBOX_PER_CYCLE];

  genvar gi;
  generate
    for (gi = 0; gi < SBOX_PER_CYCLE; gi++) begin : g_sbox
      assign box_sel[gi] = idx_reg + 3'(gi);
      assign box_din[gi] = x_reg[EXP_W - SBOX_IN_W*int'(box_sel[gi]) -: SBOX_IN_W];

      des_sbox u_sbox (
        .din  (box_din[gi]),
        .sel  (box_sel[gi]),
        .dout (box_dout[gi])
      );
    end
  endgenerate

  // idx_reg wraps to zero after the final group, so completion is judged one bit wider.
  assign last_step = (4'(idx_reg) + 4'(SBOX_PER_CYCLE)) == 4'(NUM_SBOX);

  always_comb begin
    state_next  = state_reg;
    x_next      = x_reg;
    result_next = result_reg;
    idx_next    = idx_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          x_next      = expanded ^ subkey;
          result_next = '0;
          idx_next    = '0;
          state_next  = RUN;
        end
      end
      RUN: begin
        for (int k = 0; k < SBOX_PER_CYCLE; k++) begin
          result_next[OUT_W - SBOX_OUT_W*int'(box_sel[k]) -: SBOX_OUT_W] = box_dout[k];
        end
        idx_next = idx_reg + 3'(SBOX_PER_CYCLE);
        if (last_step) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_reg  <= IDLE;
      x_reg      <= '0;
      result_reg <= '0;
      idx_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      x_reg      <= x_next;
      result_reg <= result_next;
      idx_reg    <= idx_next;
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);

`ifdef DES_SBOX_PPERM_EN
  assign sbox_out = p_perm(result_reg);
`else
  assign sbox_out = result_reg;
`endif

endmodule

// File: tb/tb_des_sbox_stage.sv
// Randomized self-checking bench for des_sbox_stage against an in-bench DES S-box model.
`timescale 1ns/1ps
module tb_des_sbox_stage;

  parameter int SPC = 1;
  localparam int LAT = 8 / SPC;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [48:1] expanded = '0;
  logic [48:1] subkey = '0;
  logic        in_ready;
  logic        out_valid;
  logic [32:1] sbox_out;

  always #5 clk = ~clk;

  des_sbox_stage #(.SBOX_PER_CYCLE(SPC)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .in_valid  (in_valid),
    .expanded  (expanded),
    .subkey    (subkey),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sbox_out  (sbox_out)
  );

  localparam logic [255:0] TB_SBOX [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D70934A6285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };

  localparam int TB_P [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25
  };

  // Reference: eight table lookups on 6-bit groups of x, MSB group first.
  function automatic logic [31:0] ref_sbox(input logic [47:0] x);
    logic [31:0]  s;
    logic [255:0] t;
    int six, row, col, val;
    s = '0;
    for (int j = 0; j < 8; j++) begin
      six = int'(x[47 - 6*j -: 6]);
      row = (six / 32) * 2 + (six % 2);
      col = (six / 2) % 16;
      t   = TB_SBOX[j];
      val = int'(t[255 - 4*(row*16 + col) -: 4]);
      s   = (s << 4) | 32'(val);
    end
    return s;
  endfunction

  function automatic logic [31:0] ref_out(input logic [47:0] x);
    logic [31:0] s;
    logic [31:0] r;
    s = ref_sbox(x);
    r = s;
`ifdef DES_SBOX_PPERM_EN
    r = '0;
    for (int i = 0; i < 32; i++) begin
      r = (r << 1) | ((s >> (32 - TB_P[i])) & 32'd1);
    end
`endif
    return r;
  endfunction

  int n_chk = 0;
  int n_pass = 0;
  int n_txn = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, got, exp);
  endtask

  // Transaction-level model: 0 = waiting, 1 = computing, 2 = result offered.
  int          m_phase = 0;
  int          m_cnt = 0;
  logic [31:0] m_exp = '0;
  bit          m_zero = 1'b1;

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      m_phase <= 0;
      m_cnt   <= 0;
      m_zero  <= 1'b1;
    end else begin
      case (m_phase)
        0: if (in_valid) begin
          m_exp   <= ref_out(expanded ^ subkey);
          m_phase <= 1;
          m_cnt   <= 0;
          m_zero  <= 1'b0;
        end
        1: begin
          m_cnt <= m_cnt + 1;
          if (m_cnt + 1 == LAT) m_phase <= 2;
        end
        default: if (out_ready) m_phase <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (n_rst) begin
      check("cyc_in_ready", 64'(in_ready), 64'(m_phase == 0));
      check("cyc_out_valid", 64'(out_valid), 64'(m_phase == 2));
      if (m_phase == 2) check("cyc_sbox_out", 64'(sbox_out), 64'(m_exp));
      else if (m_zero) check("cyc_sbox_out_cleared", 64'(sbox_out), 64'd0);
    end
  end

  task automatic run_txn(input logic [47:0] e, input logic [47:0] k, input int hold,
                         input bit scramble, input bit no_wait, input bit handoff_iv,
                         output logic [31:0] got, output int lat);
    logic [31:0] first;
    if (!no_wait) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    expanded = e;
    subkey   = k;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (lat < 20) begin
      if (scramble) begin
        expanded  = 48'({$urandom, $urandom});
        subkey    = 48'({$urandom, $urandom});
        in_valid  = 1'($urandom_range(0, 1));
        out_ready = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      lat++;
      if (out_valid) break;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("latency", 64'(lat), 64'(LAT));
    got   = sbox_out;
    first = sbox_out;
    repeat (hold) begin
      in_valid = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      check("hold_out_valid", 64'(out_valid), 64'd1);
      check("hold_sbox_out", 64'(sbox_out), 64'(first));
      check("hold_in_ready", 64'(in_ready), 64'd0);
    end
    in_valid  = handoff_iv;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("in_ready_after_handoff", 64'(in_ready), 64'd1);
    check("out_valid_after_handoff", 64'(out_valid), 64'd0);
    n_txn++;
    $display("txn %0d: x=%012h out=%08h lat=%0d hold=%0d", n_txn, e ^ k, got, lat, hold);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got;
    int          lat;
    logic [47:0] e, k;

    check("model_pin_zero", 64'(ref_sbox(48'h0)), 64'hEFA72C4D);
    check("model_pin_vector", 64'(ref_sbox(48'h7A15557A1555 ^ 48'h1B02EFFC7072)), 64'h5C82B597);

    n_rst = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    n_rst = 1'b1;
    #1;
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_sbox_out", 64'(sbox_out), 64'd0);

    // Accepted on the very first edge after reset release, then 5 cycles of backpressure.
    run_txn(48'h7A15557A1555, 48'h1B02EFFC7072, 5, 1'b0, 1'b1, 1'b1, got, lat);
`ifdef DES_SBOX_PPERM_EN
    check("known_vector_pperm", 64'(got), 64'h234AA9BB);
`else
    check("known_vector_raw", 64'(got), 64'h5C82B597);
`endif

    run_txn(48'h0, 48'h0, 0, 1'b1, 1'b0, 1'b0, got, lat);
`ifndef DES_SBOX_PPERM_EN
    check("zero_vector_raw", 64'(got), 64'hEFA72C4D);
`endif

    // Reset three edges into RUN, then a fresh transaction straight after release.
    @(posedge clk); #1;
    in_valid = 1'b1;
    expanded = 48'h123456789ABC;
    subkey   = 48'hFEDCBA987654;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    n_rst = 1'b0;
    #1;
    check("midrun_rst_in_ready", 64'(in_ready), 64'd1);
    check("midrun_rst_out_valid", 64'(out_valid), 64'd0);
    check("midrun_rst_sbox_out", 64'(sbox_out), 64'd0);
    @(negedge clk); #1;
    n_rst = 1'b1;
    run_txn(48'h7A15557A1555, 48'h1B02EFFC7072, 1, 1'b1, 1'b1, 1'b0, got, lat);
`ifdef DES_SBOX_PPERM_EN
    check("post_reset_vector", 64'(got), 64'h234AA9BB);
`else
    check("post_reset_vector", 64'(got), 64'h5C82B597);
`endif

    for (int t = 0; t < 24; t++) begin
      e = 48'({$urandom, $urandom});
      k = 48'({$urandom, $urandom});
      run_txn(e, k, int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), 1'b0,
              1'($urandom_range(0, 1)), got, lat);
      check("random_result", 64'(got), 64'(ref_out(e ^ k)));
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
